// File: rtl/pmu_sleep_sequencer.sv
// APB master that runs the fixed PMU sleep-entry transfer sequence against the wakeup slave.
// Optional macro PMU_SEQ_READBACK_EN: read back and compare every written register.
module pmu_sleep_sequencer #(
   parameter int                        APB_ADDR_WIDTH = 12,
   parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
   parameter int                        TIMEOUT_W      = 10,
   parameter logic [31:0]               SIGNATURE      = 32'h00DA41DE
) (
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic                      req_i,
   input  logic [31:0]               scratch_i,
   input  logic [31:0]               mode_i,
   input  logic                      en_i,
   output logic                      ack_o,
   output logic                      busy_o,
   output logic                      err_o,
   output logic [2:0]                err_code_o,
   output logic [APB_ADDR_WIDTH-1:0] PADDR,
   output logic [31:0]               PWDATA,
   output logic                      PWRITE,
   output logic                      PSEL,
   output logic                      PENABLE,
   input  logic [31:0]               PRDATA,
   input  logic                      PREADY,
   input  logic                      PSLVERR
);

`ifdef PMU_SEQ_READBACK_EN
   localparam logic [2:0] LAST_STEP = 3'd6;
`else
   localparam logic [2:0] LAST_STEP = 3'd3;
`endif
   // Abort on the wait cycle that would bring the counter to all-ones.
   localparam logic [TIMEOUT_W-1:0] TCNT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
   typedef enum logic [2:0] {
      ERR_NONE      = 3'd0,
      ERR_SLVERR    = 3'd1,
      ERR_TIMEOUT   = 3'd2,
      ERR_SIGNATURE = 3'd3,
      ERR_READBACK  = 3'd4
   } err_t;

   function automatic logic [3:0] step_offset(input logic [2:0] s);
`ifdef PMU_SEQ_READBACK_EN
      case (s)
         3'd1, 3'd2: return 4'h4;
         3'd3, 3'd4: return 4'hC;
         3'd5, 3'd6: return 4'h8;
         default:    return 4'h0;
      endcase
`else
      case (s)
         3'd1:    return 4'h4;
         3'd2:    return 4'hC;
         3'd3:    return 4'h8;
         default: return 4'h0;
      endcase
`endif
   endfunction

   function automatic logic step_is_write(input logic [2:0] s);
`ifdef PMU_SEQ_READBACK_EN
      return s[0];
`else
      return s != 3'd0;
`endif
   endfunction

   function automatic logic [APB_ADDR_WIDTH-1:0] step_addr(input logic [3:0] off);
      return BASE_ADDR + APB_ADDR_WIDTH'(off);
   endfunction

   state_t               state;
   logic [2:0]           step;
   logic [TIMEOUT_W-1:0] tcnt;
   logic [31:0]          scratch_q;
   logic [31:0]          mode_q;
   logic                 en_q;

   logic [2:0]           nxt_step;
   logic [3:0]           nxt_off;
   logic                 nxt_write;
   logic [31:0]          nxt_wdata;
   err_t                 xfer_err;
   logic                 end_seq;
   err_t                 end_code;
`ifdef PMU_SEQ_READBACK_EN
   logic [3:0]           cur_off;
`endif

   always_comb begin
      // NOTE: every signal gets a default first, so no path through this block can infer a latch.
      nxt_step  = step + 3'd1;
      nxt_off   = step_offset(nxt_step);
      nxt_write = step_is_write(nxt_step);
      nxt_wdata = '0;
      if (nxt_write) begin
         case (nxt_off)
            4'h4:    nxt_wdata = scratch_q;
            4'hC:    nxt_wdata = mode_q;
            4'h8:    nxt_wdata = {31'b0, en_q};
            default: nxt_wdata = '0;
         endcase
      end

      xfer_err = ERR_NONE;
`ifdef PMU_SEQ_READBACK_EN
      cur_off = step_offset(step);
`endif
      if (PSLVERR)
         xfer_err = ERR_SLVERR;
      else if (step == 3'd0 && PRDATA != SIGNATURE)
         xfer_err = ERR_SIGNATURE;
`ifdef PMU_SEQ_READBACK_EN
      else if (step != 3'd0 && !step_is_write(step)) begin
         case (cur_off)
            4'h4:    if (PRDATA != scratch_q) xfer_err = ERR_READBACK;
            4'hC:    if (PRDATA != mode_q)    xfer_err = ERR_READBACK;
            4'h8:    if (PRDATA[0] != en_q)   xfer_err = ERR_READBACK;
            default: ;
         endcase
      end
`endif

      // PREADY wins over the timeout when both land in the same cycle.
      end_seq  = 1'b0;
      end_code = ERR_NONE;
      if (state == ACCESS) begin
         if (PREADY) begin
            if (xfer_err != ERR_NONE) begin
               end_seq  = 1'b1;
               end_code = xfer_err;
            end else if (step == LAST_STEP) begin
               end_seq  = 1'b1;
            end
         end else if (tcnt == TCNT_LAST) begin
            end_seq  = 1'b1;
            end_code = ERR_TIMEOUT;
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state      <= IDLE;
         step       <= '0;
         tcnt       <= '0;
         scratch_q  <= '0;
         mode_q     <= '0;
         en_q       <= 1'b0;
         ack_o      <= 1'b0;
         busy_o     <= 1'b0;
         err_o      <= 1'b0;
         err_code_o <= '0;
         PADDR      <= '0;
         PWDATA     <= '0;
         PWRITE     <= 1'b0;
         PSEL       <= 1'b0;
         PENABLE    <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         ack_o <= 1'b0;
         case (state)
            IDLE: begin
               if (req_i) begin
                  scratch_q  <= scratch_i;
                  mode_q     <= mode_i;
                  en_q       <= en_i;
                  err_o      <= 1'b0;
                  err_code_o <= '0;
                  busy_o     <= 1'b1;
                  step       <= '0;
                  PSEL       <= 1'b1;
                  PENABLE    <= 1'b0;
                  PADDR      <= step_addr(step_offset(3'd0));
                  PWRITE     <= 1'b0;
                  PWDATA     <= '0;
                  state      <= SETUP;
               end
            end
            SETUP: begin
               PENABLE <= 1'b1;
               tcnt    <= '0;
               state   <= ACCESS;
            end
            ACCESS: begin
               if (end_seq) begin
                  PSEL       <= 1'b0;
                  PENABLE    <= 1'b0;
                  ack_o      <= 1'b1;
                  busy_o     <= 1'b0;
                  err_o      <= (end_code != ERR_NONE);
                  err_code_o <= end_code;
                  state      <= DONE;
               end else if (PREADY) begin
                  step    <= nxt_step;
                  PENABLE <= 1'b0;
                  PADDR   <= step_addr(nxt_off);
                  PWRITE  <= nxt_write;
                  PWDATA  <= nxt_wdata;
                  state   <= SETUP;
               end else begin
                  tcnt <= tcnt + TIMEOUT_W'(1);
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pmu_sleep_sequencer.sv
// Directed bench for pmu_sleep_sequencer: a configurable APB slave model on the main instance,
// plus a TIMEOUT_W=4 instance whose slave stalls writes to exercise the timeout.
module tb_pmu_sleep_sequencer;

   localparam logic [31:0] SIG = 32'h00DA41DE;
`ifdef PMU_SEQ_READBACK_EN
   localparam int NXF = 7;
`else
   localparam int NXF = 4;
`endif

   logic        HCLK, HRESETn;
   logic        req_i, t_req;
   logic [31:0] scratch_i, mode_i;
   logic        en_i;

   logic        ack_o, busy_o, err_o, PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
   logic [2:0]  err_code_o;
   logic [11:0] PADDR;
   logic [31:0] PWDATA, PRDATA;

   logic        t_ack, t_busy, t_err, t_PWRITE, t_PSEL, t_PENABLE, t_PREADY;
   logic [2:0]  t_code;
   logic [11:0] t_PADDR;
   logic [31:0] t_PWDATA;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // slave model configuration for the main instance
   logic [31:0] sig_val;
   int          write_wait;
   logic        err_en, rb_bad_en;
   logic [11:0] err_addr, rb_bad_addr;
   logic [31:0] mem [4];
   int          wcnt = 0;
   int          t_wait;
   int          t_wcnt = 0;

   // monitor state
   int          ack_count;
   int          ack_cyc;
   int          unstable;
   int          setups [4];
   logic [11:0] setup_addr;
   logic [31:0] setup_data;
   logic [11:0] wr_addr [$];
   logic [31:0] wr_data [$];
   int          t_acc4, t_setc;

   pmu_sleep_sequencer dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .req_i(req_i), .scratch_i(scratch_i), .mode_i(mode_i),
      .en_i(en_i), .ack_o(ack_o), .busy_o(busy_o), .err_o(err_o), .err_code_o(err_code_o),
      .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   pmu_sleep_sequencer #(.TIMEOUT_W(4)) dut_to (
      .HCLK(HCLK), .HRESETn(HRESETn), .req_i(t_req), .scratch_i(scratch_i), .mode_i(mode_i),
      .en_i(en_i), .ack_o(t_ack), .busy_o(t_busy), .err_o(t_err), .err_code_o(t_code),
      .PADDR(t_PADDR), .PWDATA(t_PWDATA), .PWRITE(t_PWRITE), .PSEL(t_PSEL), .PENABLE(t_PENABLE),
      .PRDATA(SIG), .PREADY(t_PREADY), .PSLVERR(1'b0)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   assign PREADY  = PSEL && PENABLE && (PWRITE ? (wcnt >= write_wait) : 1'b1);
   assign PSLVERR = PSEL && PENABLE && err_en && (PADDR == err_addr);
   assign PRDATA  = (PADDR == 12'h000) ? sig_val :
                    (rb_bad_en && PADDR == rb_bad_addr) ? 32'h0 : mem[PADDR[3:2]];
   assign t_PREADY = t_PSEL && t_PENABLE && ((t_PADDR == 12'h000) || (t_wcnt >= t_wait));

   always @(posedge HCLK) begin
      cyc    <= cyc + 1;
      wcnt   <= (PSEL && PENABLE && !PREADY) ? wcnt + 1 : 0;
      t_wcnt <= (t_PSEL && t_PENABLE && !t_PREADY) ? t_wcnt + 1 : 0;
      if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR[3:2]] <= PWDATA;
   end

   always @(negedge HCLK) begin
      if (ack_o) begin
         ack_count++;
         ack_cyc = cyc;
      end
      if (PSEL && !PENABLE) begin
         setup_addr = PADDR;
         setup_data = PWDATA;
         setups[PADDR[3:2]]++;
      end
      if (PSEL && PENABLE && (PADDR !== setup_addr || PWDATA !== setup_data)) unstable++;
      if (PSEL && PENABLE && PREADY && PWRITE) begin
         wr_addr.push_back(PADDR);
         wr_data.push_back(PWDATA);
      end
      if (t_PSEL && t_PENABLE && t_PADDR == 12'h004) t_acc4++;
      if (t_PSEL && !t_PENABLE && t_PADDR == 12'h00C) t_setc++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      ack_count = 0;
      ack_cyc   = 0;
      unstable  = 0;
      for (int i = 0; i < 4; i++) setups[i] = 0;
      wr_addr.delete();
      wr_data.delete();
      t_acc4 = 0;
      t_setc = 0;
   endtask

   // Pulse a one-cycle request on the chosen instance; returns the index of the sampling edge.
   task automatic pulse_req(input bit to_inst, output int edge_n);
      @(negedge HCLK); #1;
      if (to_inst) t_req = 1'b1; else req_i = 1'b1;
      @(posedge HCLK);
      edge_n = cyc;
      @(negedge HCLK); #1;
      t_req = 1'b0;
      req_i = 1'b0;
   endtask

   task automatic wait_ack(input bit to_inst, input int budget, output bit got, output int at);
      got = 1'b0;
      at  = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge HCLK); #1;
         if (to_inst ? t_ack : ack_o) begin
            got = 1'b1;
            at  = cyc;
            break;
         end
      end
   endtask

   task automatic check_writes(input string tag, input logic [31:0] s, input logic [31:0] m,
                               input logic e);
      check({tag, "_wr_count"}, wr_addr.size(), 3);
      if (wr_addr.size() == 3) begin
         check({tag, "_wr0_addr"}, {20'h0, wr_addr[0]}, 32'h004);
         check({tag, "_wr0_data"}, wr_data[0], s);
         check({tag, "_wr1_addr"}, {20'h0, wr_addr[1]}, 32'h00C);
         check({tag, "_wr1_data"}, wr_data[1], m);
         check({tag, "_wr2_addr"}, {20'h0, wr_addr[2]}, 32'h008);
         check({tag, "_wr2_data"}, wr_data[2], {31'b0, e});
      end
   endtask

   initial begin
      int  n, n2, at;
      bit  got, found;

      HRESETn = 1'b0; req_i = 1'b0; t_req = 1'b0;
      scratch_i = '0; mode_i = '0; en_i = 1'b0;
      sig_val = SIG; write_wait = 0; err_en = 1'b0; err_addr = '0;
      rb_bad_en = 1'b0; rb_bad_addr = '0; t_wait = 0;
      for (int i = 0; i < 4; i++) mem[i] = '0;
      clear_logs();
      repeat (3) @(negedge HCLK);
      #1;
      check("rst_ctrl", {26'h0, PSEL, PENABLE, PWRITE, ack_o, busy_o, err_o}, 32'h0);
      check("rst_code", {29'h0, err_code_o}, 32'h0);
      check("rst_paddr", {20'h0, PADDR}, 32'h0);
      check("rst_pwdata", PWDATA, 32'h0);
      HRESETn = 1'b1;

      // zero-wait slave, full sequence; inputs change after acceptance
      clear_logs();
      scratch_i = 32'hCAFE0001; mode_i = 32'h5; en_i = 1'b1;
      pulse_req(1'b0, n);
      scratch_i = 32'hFFFF_FFFF; mode_i = 32'h0; en_i = 1'b0;
      check("zw_busy", {31'h0, busy_o}, 32'h1);
      wait_ack(1'b0, 100, got, at);
      check("zw_ack_seen", {31'h0, got}, 32'h1);
      check("zw_ack_latency", at - n, 2 * NXF + 1);
      check("zw_err", {28'h0, err_o, err_code_o}, 32'h0);
      check("zw_busy_end", {31'h0, busy_o}, 32'h0);
      check_writes("zw", 32'hCAFE0001, 32'h5, 1'b1);
      @(negedge HCLK); #1;
      check("zw_ack_one_cycle", {31'h0, ack_o}, 32'h0);

      // 40 wait states on every write
      clear_logs();
      write_wait = 40;
      scratch_i = 32'h1234_5678; mode_i = 32'hA; en_i = 1'b0;
      pulse_req(1'b0, n);
      wait_ack(1'b0, 400, got, at);
      check("st_ack_seen", {31'h0, got}, 32'h1);
      check("st_ack_latency", at - n, 2 * NXF + 1 + 120);
      check("st_stable", unstable, 0);
      check("st_err", {28'h0, err_o, err_code_o}, 32'h0);
      check_writes("st", 32'h1234_5678, 32'hA, 1'b0);
      write_wait = 0;

      // bad signature: no writes, code 3, PSEL already low with ack
      clear_logs();
      sig_val = 32'h0;
      pulse_req(1'b0, n);
      wait_ack(1'b0, 100, got, at);
      check("sig_ack_seen", {31'h0, got}, 32'h1);
      check("sig_ack_latency", at - n, 3);
      check("sig_err", {28'h0, err_o, err_code_o}, {28'h0, 1'b1, 3'd3});
      check("sig_psel_low", {30'h0, PSEL, PENABLE}, 32'h0);
      check("sig_no_writes", wr_addr.size(), 0);
      sig_val = SIG;

      // slave error on the mode write, plus an ignored second request
      clear_logs();
      err_en = 1'b1; err_addr = 12'h00C;
      pulse_req(1'b0, n);
      pulse_req(1'b0, n2);
      wait_ack(1'b0, 100, got, at);
      check("slv_ack_seen", {31'h0, got}, 32'h1);
`ifdef PMU_SEQ_READBACK_EN
      check("slv_ack_latency", at - n, 9);
`else
      check("slv_ack_latency", at - n, 7);
`endif
      check("slv_err", {28'h0, err_o, err_code_o}, {28'h0, 1'b1, 3'd1});
      repeat (20) @(negedge HCLK);
      #1;
      check("slv_single_ack", ack_count, 1);
      check("slv_no_en_step", setups[2], 0);
      check("slv_err_held", {29'h0, err_code_o}, 32'd1);
      err_en = 1'b0;

      // asynchronous reset during ACCESS of step 1
      clear_logs();
      write_wait = 5;
      pulse_req(1'b0, n);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge HCLK); #1;
         if (PSEL && PENABLE && PADDR == 12'h004) begin
            found = 1'b1;
            break;
         end
      end
      check("mid_found_access", {31'h0, found}, 32'h1);
      HRESETn = 1'b0;
      #1;
      check("mid_rst_ctrl", {23'h0, PSEL, PENABLE, PWRITE, ack_o, busy_o, err_o, err_code_o}, 32'h0);
      check("mid_rst_bus", {20'h0, PADDR} | PWDATA, 32'h0);
      repeat (2) @(negedge HCLK);
      HRESETn = 1'b1;
      repeat (10) @(negedge HCLK);
      #1;
      check("mid_no_ack", ack_count, 0);
      write_wait = 0;

      // fresh sequence after reset
      clear_logs();
      scratch_i = 32'h0BAD_F00D; mode_i = 32'h3; en_i = 1'b1;
      pulse_req(1'b0, n);
      wait_ack(1'b0, 100, got, at);
      check("post_ack_seen", {31'h0, got}, 32'h1);
      check("post_ack_latency", at - n, 2 * NXF + 1);
      check("post_err", {28'h0, err_o, err_code_o}, 32'h0);
      check_writes("post", 32'h0BAD_F00D, 32'h3, 1'b1);

`ifdef PMU_SEQ_READBACK_EN
      // readback of the mode register returns 0
      clear_logs();
      rb_bad_en = 1'b1; rb_bad_addr = 12'h00C;
      pulse_req(1'b0, n);
      wait_ack(1'b0, 100, got, at);
      check("rb_ack_seen", {31'h0, got}, 32'h1);
      check("rb_ack_latency", at - n, 11);
      check("rb_err", {28'h0, err_o, err_code_o}, {28'h0, 1'b1, 3'd4});
      check("rb_no_en_step", setups[2], 0);
      rb_bad_en = 1'b0;
`endif

      // TIMEOUT_W=4 instance: PREADY never comes on step 1
      clear_logs();
      t_wait = 1000;
      pulse_req(1'b1, n);
      wait_ack(1'b1, 100, got, at);
      check("to_ack_seen", {31'h0, got}, 32'h1);
      check("to_ack_latency", at - n, 19);
      check("to_err", {28'h0, t_err, t_code}, {28'h0, 1'b1, 3'd2});
      check("to_access_cycles", t_acc4, 15);
      check("to_psel_low", {30'h0, t_PSEL, t_PENABLE}, 32'h0);
      repeat (5) @(negedge HCLK);
      #1;
      check("to_no_step2", t_setc, 0);

      // PREADY on the terminal-count cycle of every stalled transfer still succeeds
      clear_logs();
      t_wait = 14;
      pulse_req(1'b1, n);
      wait_ack(1'b1, 300, got, at);
      check("tc_ack_seen", {31'h0, got}, 32'h1);
      check("tc_ack_latency", at - n, 2 + (NXF - 1) * 16 + 1);
      check("tc_err", {28'h0, t_err, t_code}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
